sdlc_deframer: RTL and testbench

- Bit-level SDLC/HDLC receive deframer.
- Sits directly downstream of the DPLL bit-clock recovery stage. Consumes the recovered bit strobe `rx_rdy` and the line input `rx_data`.
- Performs optional NRZI decoding, flag detection, zero-bit destuffing and abort detection. Assembles octets LSB-first.
- Checks the CRC-16/CCITT FCS, then presents bytes plus frame-delimiter strobes to the downstream byte FIFO / DMA.

---
 rtl/sdlc_pkg.sv | 21 ++
 rtl/sdlc_crc16_byte.sv | 25 ++
 rtl/sdlc_deframer.sv | 173 +++++++++++++++++
 tb/tb_sdlc_deframer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdlc_pkg.sv
// sdlc_pkg: shared definitions for the SDLC/HDLC receive deframer.
//   - state_t     : framing state (HUNT, SYNC, DATA)
//   - *_ONES      : ones-run lengths that mark stuffing, flag and abort
//   - CRC_*       : CRC-16/CCITT (reflected) constants for the FCS check
package sdlc_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,  // waiting for a flag, data ignored
    SYNC = 2'd1,  // just saw a flag, frame not yet started
    DATA = 2'd2   // inside a frame
  } state_t;

  localparam logic [2:0] STUFF_ONES = 3'd5;
  localparam logic [2:0] FLAG_ONES  = 3'd6;
  localparam logic [2:0] ABORT_ONES = 3'd7;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_GOOD = 16'hF0B8;

endpackage

// File: rtl/sdlc_crc16_byte.sv
// sdlc_crc16_byte: one-byte update of the reflected CRC-16/CCITT register.
// Ports:
//   crc_in  [15:0] : current CRC register
//   data    [7:0]  : octet to fold in (bit 0 first on the line)
//   crc_out [15:0] : CRC register after the octet
module sdlc_crc16_byte
  import sdlc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // NOTE: every variable gets a value before any branch so no latch is inferred.
  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/sdlc_deframer.sv
// sdlc_deframer: bit-level SDLC/HDLC receive deframer.
// Optional NRZI decode, flag detection, zero-bit destuffing, abort detection,
// LSB-first octet assembly and CRC-16/CCITT FCS check.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   rx_data, rx_rdy : serial line bit and its one-clk sample strobe
//   rx_byte         : last assembled octet (held)
//   rx_byte_valid   : one-clk pulse per octet, FCS octets included
//   rx_sof          : pulse with the first octet of a frame
//   rx_eof          : pulse at the closing flag of a non-empty frame
//   rx_fcs_ok       : with rx_eof, CRC residue good and no framing error (held)
//   rx_err          : with rx_eof, misaligned or too-short frame (held)
//   rx_abort        : pulse on seven ones inside a frame
//   rx_active       : high while inside a frame
module sdlc_deframer
  import sdlc_pkg::*;
#(
  parameter bit NRZI      = 1'b0,
  parameter int MIN_BYTES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data,
  input  logic       rx_rdy,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_fcs_ok,
  output logic       rx_err,
  output logic       rx_abort,
  output logic       rx_active
);

  localparam logic [15:0] MIN_CNT = 16'(MIN_BYTES);

  state_t      state;
  logic [2:0]  ones_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_sr;
  logic [15:0] byte_cnt;
  logic [15:0] crc;
  logic        prev_line;

  logic        d;
  logic        is_flag;
  logic        is_abort;
  logic        is_data;
  logic        byte_done;
  logic        frame_err;
  logic [2:0]  ones_next;
  logic [7:0]  byte_next;
  logic [15:0] crc_next;

  // Classify the current bit. A zero after five ones is a stuffed zero and is
  // neither flag nor data; the sixth one is held (not data) until the next bit
  // decides between flag and abort.
  always_comb begin
    d         = NRZI ? (rx_data == prev_line) : rx_data;
    is_flag   = 1'b0;
    is_abort  = 1'b0;
    is_data   = 1'b0;
    ones_next = 3'd0;
    if (!d) begin
      is_flag = (ones_cnt == FLAG_ONES);
      is_data = (ones_cnt != FLAG_ONES) && (ones_cnt != STUFF_ONES);
    end else begin
      ones_next = (ones_cnt == ABORT_ONES) ? ABORT_ONES : ones_cnt + 3'd1;
      is_abort  = (ones_cnt == FLAG_ONES);
      is_data   = (ones_cnt < STUFF_ONES);
    end
    byte_next = {d, byte_sr[7:1]};
    byte_done = is_data && (bit_cnt == 3'd7);
    // An aligned frame ends with the flag's leading 0 plus five 1s shifted in.
    frame_err = (bit_cnt != 3'd6) || (byte_cnt < MIN_CNT);
  end

  sdlc_crc16_byte u_crc (
    .crc_in  (crc),
    .data    (byte_next),
    .crc_out (crc_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= HUNT;
      ones_cnt      <= ABORT_ONES;
      bit_cnt       <= 3'd0;
      byte_sr       <= 8'h00;
      byte_cnt      <= 16'd0;
      crc           <= CRC_INIT;
      prev_line     <= 1'b1;
      rx_byte       <= 8'h00;
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_fcs_ok     <= 1'b0;
      rx_err        <= 1'b0;
      rx_abort      <= 1'b0;
      rx_active     <= 1'b0;
    end else begin
      rx_byte_valid <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_abort      <= 1'b0;
      if (rx_rdy) begin
        prev_line <= rx_data;
        ones_cnt  <= ones_next;

        if (state != HUNT && is_data) begin
          byte_sr <= byte_next;
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            rx_byte       <= byte_next;
            rx_byte_valid <= 1'b1;
            rx_sof        <= (byte_cnt == 16'd0);
            crc           <= crc_next;
            if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
          end
        end

        case (state)
          HUNT: begin
            if (is_flag) begin
              state    <= SYNC;
              bit_cnt  <= 3'd0;
              byte_cnt <= 16'd0;
              crc      <= CRC_INIT;
            end
          end
          SYNC: begin
            if (is_flag) begin
              bit_cnt  <= 3'd0;
              byte_cnt <= 16'd0;
              crc      <= CRC_INIT;
            end else if (is_abort) begin
              state <= HUNT;
            end else if (is_data) begin
              state     <= DATA;
              rx_active <= 1'b1;
            end
          end
          DATA: begin
            if (is_flag) begin
              // An empty flag pair is just a repeated flag.
              if (byte_cnt != 16'd0) begin
                rx_eof    <= 1'b1;
                rx_err    <= frame_err;
                rx_fcs_ok <= !frame_err && (crc == CRC_GOOD);
              end
              state     <= SYNC;
              rx_active <= 1'b0;
              bit_cnt   <= 3'd0;
              byte_cnt  <= 16'd0;
              crc       <= CRC_INIT;
            end else if (is_abort) begin
              rx_abort  <= 1'b1;
              state     <= HUNT;
              rx_active <= 1'b0;
            end
          end
          default: begin
            state     <= HUNT;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdlc_deframer.sv
// tb_sdlc_deframer: drives one NRZ and one NRZI instance of sdlc_deframer
// with the same decoded bit stream and compares the observed event logs
// against events predicted from a frame-level model.
module tb_sdlc_deframer;

  typedef logic [11:0] ev_t;  // [11:10] kind 1=byte 2=eof 3=abort 0=stray sof

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_rdy = 1'b0;
  logic rx_data0 = 1'b1;
  logic rx_data1 = 1'b1;

  logic [7:0] rx_byte0, rx_byte1;
  logic bv0, bv1, sof0, sof1, eof0, eof1, ok0, ok1, err0, err1, ab0, ab1, act0, act1;

  int total = 0;
  int bad = 0;

  ev_t ev0[$];
  ev_t ev1[$];
  ev_t exp_q[$];
  bit fbits[$];
  logic [7:0] pay[$];

  logic line1 = 1'b1;
  int tx_ones = 0;
  bit in_frame = 1'b0;

  always #5 clk = ~clk;

  sdlc_deframer #(.NRZI(1'b0), .MIN_BYTES(3)) dut_nrz (
    .clk(clk), .reset(reset), .rx_data(rx_data0), .rx_rdy(rx_rdy),
    .rx_byte(rx_byte0), .rx_byte_valid(bv0), .rx_sof(sof0), .rx_eof(eof0),
    .rx_fcs_ok(ok0), .rx_err(err0), .rx_abort(ab0), .rx_active(act0)
  );

  sdlc_deframer #(.NRZI(1'b1), .MIN_BYTES(3)) dut_nrzi (
    .clk(clk), .reset(reset), .rx_data(rx_data1), .rx_rdy(rx_rdy),
    .rx_byte(rx_byte1), .rx_byte_valid(bv1), .rx_sof(sof1), .rx_eof(eof1),
    .rx_fcs_ok(ok1), .rx_err(err1), .rx_abort(ab1), .rx_active(act1)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (bv0 || sof0) ev0.push_back({bv0 ? 2'd1 : 2'd0, sof0, 1'b0, rx_byte0});
      if (eof0) ev0.push_back({2'd2, ok0, err0, 8'h00});
      if (ab0) ev0.push_back({2'd3, 10'd0});
      if (bv1 || sof1) ev1.push_back({bv1 ? 2'd1 : 2'd0, sof1, 1'b0, rx_byte1});
      if (eof1) ev1.push_back({2'd2, ok1, err1, 8'h00});
      if (ab1) ev1.push_back({2'd3, 10'd0});
    end
  end

  function automatic int ev_count(input int u);
    return (u == 0) ? ev0.size() : ev1.size();
  endfunction

  function automatic ev_t ev_at(input int u, input int i);
    return (u == 0) ? ev0[i] : ev1[i];
  endfunction

  // Bitwise reflected CRC-16/CCITT, one line bit at a time.
  function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    end
    return c;
  endfunction

  // ---------------- line driver ----------------
  task automatic send_bit(input bit b);
    if (!b) line1 = ~line1;  // NRZI: a zero is a transition
    rx_data0 = b;
    rx_data1 = line1;
    rx_rdy = 1'b1;
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
  endtask

  // Transmitter-side zero insertion after five data ones.
  task automatic send_data_bit(input bit b);
    send_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin send_bit(1'b0); tx_ones = 0; end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_flag();
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit(1'b0);
    tx_ones = 0;
    in_frame = 1'b1;
  endtask

  // n flags sharing their zeros: 0 111111 0 111111 0 ...
  task automatic send_shared_flags(input int n);
    send_bit(1'b0);
    repeat (n) begin
      repeat (6) send_bit(1'b1);
      send_bit(1'b0);
    end
    tx_ones = 0;
    in_frame = 1'b1;
  endtask

  // Idle ones; seven or more ones after a flag abort whatever followed it.
  task automatic send_idle(input int n);
    repeat (n) send_bit(1'b1);
    if (in_frame && n >= 7) exp_q.push_back({2'd3, 10'd0});
    in_frame = 1'b0;
    tx_ones = 0;
  endtask

  task automatic send_fbits();
    foreach (fbits[i]) send_data_bit(fbits[i]);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) fbits.push_back(b[j]);
  endtask

  task automatic add_pay_with_fcs();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay[i]) begin
      c = crc_bits(c, pay[i]);
      add_byte(pay[i]);
    end
    add_byte(~c[7:0]);
    add_byte(~c[15:8]);
  endtask

  // Frame model: the receiver sees the data bits plus the closing flag's
  // leading 0 and five 1s; whole octets are bytes, a remainder other than
  // six or fewer than three octets is an error, and a good frame leaves the
  // CRC residue 0xF0B8.
  task automatic model_frame(input bit closed);
    bit all[$];
    int nb, rem;
    logic [15:0] c;
    logic [7:0] b;
    bit e;
    all = fbits;
    if (closed) begin
      all.push_back(1'b0);
      repeat (5) all.push_back(1'b1);
    end
    nb = all.size() / 8;
    rem = all.size() % 8;
    c = 16'hFFFF;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 8; j++) b[j] = all[8 * k + j];
      c = crc_bits(c, b);
      exp_q.push_back({2'd1, (k == 0), 1'b0, b});
    end
    if (closed && nb > 0) begin
      e = (rem != 6) || (nb < 3);
      exp_q.push_back({2'd2, !e && (c == 16'hF0B8), e, 8'h00});
    end
  endtask

  task automatic start_test();
    ev0.delete(); ev1.delete(); exp_q.delete(); fbits.delete(); pay.delete();
  endtask

  task automatic finish_test(input string name);
    repeat (4) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      total++;
      if (ev_count(u) !== exp_q.size()) begin
        bad++;
        $display("FAIL %s dut%0d event count: got %0d want %0d", name, u, ev_count(u), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < ev_count(u); i++) begin
        total++;
        if (ev_at(u, i) !== exp_q[i]) begin
          bad++;
          $display("FAIL %s dut%0d event %0d: got %h want %h", name, u, i, ev_at(u, i), exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rx_byte0, bv0, sof0, eof0, ok0, err0, ab0, act0} !== 15'd0) begin
      bad++;
      $display("FAIL reset nrz outputs: got %h want 0", {rx_byte0, bv0, sof0, eof0, ok0, err0, ab0, act0});
    end
    total++;
    if ({rx_byte1, bv1, sof1, eof1, ok1, err1, ab1, act1} !== 15'd0) begin
      bad++;
      $display("FAIL reset nrzi outputs: got %h want 0", {rx_byte1, bv1, sof1, eof1, ok1, err1, ab1, act1});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    logic [7:0] msg[11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                            8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    start_test();
    send_idle(10);
    send_flag();
    foreach (msg[i]) add_byte(msg[i]);
    send_fbits();
    send_flag();
    model_frame(1'b1);
    @(posedge clk); #1;
    total++;
    if ({rx_byte0, ok0, err0, rx_byte1, ok1, err1} !== {8'h90, 2'b10, 8'h90, 2'b10}) begin
      bad++;
      $display("FAIL good_frame held byte/ok/err: got %h want %h",
               {rx_byte0, ok0, err0, rx_byte1, ok1, err1}, {8'h90, 2'b10, 8'h90, 2'b10});
    end
    send_idle(10);
    finish_test("good_frame");
  endtask

  task automatic test_bad_fcs();
    logic [7:0] msg[11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h34, 8'h36,
                            8'h37, 8'h38, 8'h39, 8'h6E, 8'h90};
    start_test();
    send_flag();
    foreach (msg[i]) add_byte(msg[i]);
    send_fbits();
    send_flag();
    model_frame(1'b1);
    send_idle(10);
    finish_test("bad_fcs");
  endtask

  task automatic test_stuffing();
    start_test();
    send_flag();
    pay.push_back(8'hFF);
    pay.push_back(8'h7E);
    add_pay_with_fcs();
    send_fbits();
    send_flag();
    model_frame(1'b1);
    send_idle(10);
    total++;
    if ({ok0, ok1} !== 2'b11) begin
      bad++;
      $display("FAIL stuffing fcs_ok held: got %b want 11", {ok0, ok1});
    end
    finish_test("stuffing");
  endtask

  task automatic test_abort();
    start_test();
    send_flag();
    add_byte(8'h31);
    add_byte(8'h32);
    send_fbits();
    model_frame(1'b0);
    @(posedge clk); #1;
    total++;
    if ({act0, act1} !== 2'b11) begin
      bad++;
      $display("FAIL abort active before: got %b want 11", {act0, act1});
    end
    send_idle(7);
    @(posedge clk); #1;
    total++;
    if ({act0, act1} !== 2'b00) begin
      bad++;
      $display("FAIL abort active after: got %b want 00", {act0, act1});
    end
    send_idle(5);
    finish_test("abort");
  endtask

  task automatic test_misaligned();
    logic [2:0] extra;
    start_test();
    extra = 3'($urandom);
    send_flag();
    add_byte(8'h31);
    add_byte(8'h32);
    for (int j = 0; j < 3; j++) fbits.push_back(extra[j]);
    send_fbits();
    send_flag();
    model_frame(1'b1);
    send_idle(10);
    finish_test("misaligned");
  endtask

  task automatic test_shared_flags();
    start_test();
    send_shared_flags(3);
    repeat (1 + $urandom_range(4, 0)) pay.push_back(8'($urandom));
    add_pay_with_fcs();
    send_fbits();
    send_flag();
    model_frame(1'b1);
    send_idle(10);
    finish_test("shared_flags");
  endtask

  // Back-to-back frames sharing flags: minimum-length good frame, a two-octet
  // short frame, then random good, corrupted and short frames.
  task automatic test_back_to_back();
    int mode, len;
    start_test();
    send_flag();
    for (int f = 0; f < 8; f++) begin
      fbits.delete();
      pay.delete();
      mode = (f == 0) ? 0 : (f == 1) ? 2 : int'($urandom_range(2, 0));
      len = (f == 0) ? 1 : (f == 1) ? 2 : int'($urandom_range(6, 1));
      if (mode == 2 && len > 2) len = 2;
      repeat (len) pay.push_back(8'($urandom));
      if (mode == 2) begin
        foreach (pay[i]) add_byte(pay[i]);
      end else begin
        add_pay_with_fcs();
        if (mode == 1) begin
          int p;
          p = int'($urandom_range(8 * len - 1, 0));
          fbits[p] = ~fbits[p];
        end
      end
      send_fbits();
      send_flag();
      model_frame(1'b1);
    end
    send_idle(10);
    finish_test("back_to_back");
  endtask

  task automatic test_reset_mid_frame();
    start_test();
    send_flag();
    add_byte(8'hA5);
    add_byte(8'h5A);
    send_fbits();
    @(posedge clk); #1;
    total++;
    if ({act0, act1} !== 2'b11) begin
      bad++;
      $display("FAIL reset_mid active before: got %b want 11", {act0, act1});
    end
    ev0.delete(); ev1.delete();
    reset = 1'b1;
    #1;
    total++;
    if ({rx_byte0, bv0, sof0, eof0, ok0, err0, ab0, act0, rx_byte1, bv1, sof1, eof1, ok1, err1, ab1, act1} !== 30'd0) begin
      bad++;
      $display("FAIL reset_mid outputs: got %h want 0",
               {rx_byte0, bv0, sof0, eof0, ok0, err0, ab0, act0, rx_byte1, bv1, sof1, eof1, ok1, err1, ab1, act1});
    end
    line1 = 1'b1;
    tx_ones = 0;
    in_frame = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    send_idle(10);
    total++;
    if (ev0.size() + ev1.size() !== 0) begin
      bad++;
      $display("FAIL reset_mid stray events: got %0d want 0", ev0.size() + ev1.size());
    end
    fbits.delete();
    send_flag();
    repeat (3) pay.push_back(8'($urandom));
    add_pay_with_fcs();
    send_fbits();
    send_flag();
    model_frame(1'b1);
    send_idle(10);
    finish_test("reset_mid_frame");
  endtask

  initial begin
    #1;
    test_reset();
    test_good_frame();
    test_bad_fcs();
    test_stuffing();
    test_abort();
    test_misaligned();
    test_shared_flags();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
